// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: width codes,
// FSM states and the per-width base byte strobe.
package dmem_access_unit_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width code 11 falls through to a full word.
    function automatic logic [3:0] base_strb(input logic [1:0] width);
        case (width)
            MEM_W_BYTE: base_strb = 4'b0001;
            MEM_W_HALF: base_strb = 4'b0011;
            default:    base_strb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// Combinational lane steering: store strobes/data for both bus beats, the
// split decision, and reassembly plus extension of load data.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
#(
    parameter int SPLIT = 1
) (
    input  logic [1:0]  k,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  strb0,
    output logic [3:0]  strb1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic        split,
    output logic [31:0] load_data
);

    logic [7:0]  strb_wide;
    logic [63:0] wdata_wide;
    logic [31:0] load_raw;
    logic [4:0]  bit_shift;

    assign bit_shift = {k, 3'b000};

    // Bits shifted past lane 3 land in the upper half and form beat 1.
    always_comb begin
        strb_wide  = {4'b0000, base_strb(width)} << k;
        wdata_wide = {32'h0, wdata} << bit_shift;
        load_raw   = 32'({rdata_hi, rdata_lo} >> bit_shift);
        strb0      = strb_wide[3:0];
        strb1      = strb_wide[7:4];
        wdata0     = wdata_wide[31:0];
        wdata1     = wdata_wide[63:32];
        split      = (SPLIT != 0) && (strb_wide[7:4] != 4'b0000);
    end

    always_comb begin
        case (width)
            MEM_W_BYTE: load_data = {{24{sign_ext & load_raw[7]}}, load_raw[7:0]};
            MEM_W_HALF: load_data = {{16{sign_ext & load_raw[15]}}, load_raw[15:0]};
            default:    load_data = load_raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory responder: runs one load/store from EX/MEM on a
// handshaked word bus, splitting misaligned accesses, and stalls upstream.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SPLIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_sign_ext_i,
    input  logic              mem_write_i,
    input  logic              mem_read_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        strb_reg, strb_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic [1:0]        k_reg, k_next;
    logic [1:0]        width_reg, width_next;
    logic              sext_reg, sext_next;
    logic [31:0]       st_wdata_reg, st_wdata_next;
    logic [31:0]       lo_reg, lo_next;

    logic        pending;
    logic        idle;
    logic [1:0]  al_k;
    logic [1:0]  al_width;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata_lo;
    logic [31:0] al_rdata_hi;
    logic [3:0]  al_strb0, al_strb1;
    logic [31:0] al_wdata0, al_wdata1;
    logic        al_split;
    logic [31:0] al_load;

    assign pending = mem_write_i | mem_read_i;
    assign stall_o = pending & (state_reg != DONE);
    assign idle    = (state_reg == IDLE);

    // In IDLE the aligner sees the live request; afterwards the latched copy.
    assign al_k        = idle ? addr_i[1:0]  : k_reg;
    assign al_width    = idle ? mem_width_i  : width_reg;
    assign al_wdata    = idle ? wdata_i      : st_wdata_reg;
    assign al_rdata_lo = (state_reg == BEAT1) ? lo_reg      : mem_rdata_i;
    assign al_rdata_hi = (state_reg == BEAT1) ? mem_rdata_i : 32'h0;

    dmem_lane_align #(.SPLIT(SPLIT)) u_align (
        .k         (al_k),
        .width     (al_width),
        .sign_ext  (sext_reg),
        .wdata     (al_wdata),
        .rdata_lo  (al_rdata_lo),
        .rdata_hi  (al_rdata_hi),
        .strb0     (al_strb0),
        .strb1     (al_strb1),
        .wdata0    (al_wdata0),
        .wdata1    (al_wdata1),
        .split     (al_split),
        .load_data (al_load)
    );

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        strb_next     = strb_reg;
        rdata_next    = rdata_reg;
        k_next        = k_reg;
        width_next    = width_reg;
        sext_next     = sext_reg;
        st_wdata_next = st_wdata_reg;
        lo_next       = lo_reg;
        case (state_reg)
            IDLE: begin
                if (pending) begin
                    k_next        = addr_i[1:0];
                    width_next    = mem_width_i;
                    sext_next     = mem_sign_ext_i;
                    st_wdata_next = wdata_i;
                    req_next      = 1'b1;
                    we_next       = mem_write_i;
                    addr_next     = {addr_i[ADDR_W-1:2], 2'b00};
                    wdata_next    = al_wdata0;
                    strb_next     = al_strb0;
                    state_next    = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ack_i) begin
                    lo_next = mem_rdata_i;
                    if (al_split) begin
                        addr_next  = addr_reg + ADDR_W'(4);
                        wdata_next = al_wdata1;
                        strb_next  = al_strb1;
                        state_next = BEAT1;
                    end else begin
                        req_next   = 1'b0;
                        state_next = DONE;
                        if (!we_reg) rdata_next = al_load;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack_i) begin
                    req_next   = 1'b0;
                    state_next = DONE;
                    if (!we_reg) rdata_next = al_load;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            strb_reg     <= 4'h0;
            rdata_reg    <= 32'h0;
            k_reg        <= 2'b00;
            width_reg    <= 2'b00;
            sext_reg     <= 1'b0;
            st_wdata_reg <= 32'h0;
            lo_reg       <= 32'h0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            strb_reg     <= strb_next;
            rdata_reg    <= rdata_next;
            k_reg        <= k_next;
            width_reg    <= width_next;
            sext_reg     <= sext_next;
            st_wdata_reg <= st_wdata_next;
            lo_reg       <= lo_next;
        end
    end

    assign mem_req_o   = req_reg;
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign mem_wstrb_o = strb_reg;
    assign rdata_o     = rdata_reg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a small bus-slave memory with
// programmable ack delay, and hand-computed expectations per access.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [1:0]  mem_width_i = 2'b00;
    logic        mem_sign_ext_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    dmem_access_unit #(.ADDR_W(32), .SPLIT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .mem_width_i    (mem_width_i),
        .mem_sign_ext_i (mem_sign_ext_i),
        .mem_write_i    (mem_write_i),
        .mem_read_i     (mem_read_i),
        .stall_o        (stall_o),
        .rdata_o        (rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wstrb_o    (mem_wstrb_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:255];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          beat_cnt = 0;
    int          unstable = 0;
    logic [31:0] beat_addr [0:3];
    logic [31:0] beat_wdata [0:3];
    logic [3:0]  beat_strb [0:3];
    logic        beat_we [0:3];
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_wdata = 32'h0;
    logic [3:0]  prev_strb = 4'h0;

    // Bus slave: acks after ack_delay waiting cycles, one ack per beat.
    always @(negedge clk) begin
        if (!rst && mem_req_o && prev_req && !prev_ack &&
            (mem_addr_o != prev_addr || mem_wdata_o != prev_wdata ||
             mem_wstrb_o != prev_strb || mem_we_o != prev_we))
            unstable = unstable + 1;
        prev_req   = mem_req_o;
        prev_addr  = mem_addr_o;
        prev_wdata = mem_wdata_o;
        prev_strb  = mem_wstrb_o;
        prev_we    = mem_we_o;
        if (mem_req_o && !rst) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = tb_mem[mem_addr_o[9:2]];
                if (beat_cnt < 4) begin
                    beat_addr[beat_cnt]  = mem_addr_o;
                    beat_wdata[beat_cnt] = mem_wdata_o;
                    beat_strb[beat_cnt]  = mem_wstrb_o;
                    beat_we[beat_cnt]    = mem_we_o;
                end
                if (mem_we_o)
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb_o[b])
                            tb_mem[mem_addr_o[9:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
                beat_cnt = beat_cnt + 1;
                wait_cnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
        end
        prev_ack = mem_ack_i;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Presents one request and waits (bounded) for the DONE cycle; returns
    // with the unit in DONE and the request withdrawn.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w,
                          input logic se, input logic we, input logic re, input int dly,
                          output int stall_cycles);
        beat_cnt       = 0;
        ack_delay      = dly;
        addr_i         = a;
        wdata_i        = wd;
        mem_width_i    = w;
        mem_sign_ext_i = se;
        mem_write_i    = we;
        mem_read_i     = re;
        stall_cycles   = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_o) break;
            stall_cycles++;
            @(posedge clk);
            #1;
        end
        mem_write_i = 1'b0;
        mem_read_i  = 1'b0;
    endtask

    task automatic to_idle();
        @(posedge clk);
        #2;
    endtask

    int sc;

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_req",   {31'h0, mem_req_o}, 32'h0);
        chk("reset_we",    {31'h0, mem_we_o},  32'h0);
        chk("reset_strb",  {28'h0, mem_wstrb_o}, 32'h0);
        chk("reset_addr",  mem_addr_o,  32'h0);
        chk("reset_wdata", mem_wdata_o, 32'h0);
        chk("reset_rdata", rdata_o,     32'h0);
        chk("reset_stall", {31'h0, stall_o}, 32'h0);
        rst = 1'b0;
        to_idle();

        // sw 0xDEADBEEF @0x100, immediate ack
        access(32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 1'b0, 0, sc);
        chk("sw_stall",  sc, 2);
        chk("sw_beats",  beat_cnt, 1);
        chk("sw_addr",   beat_addr[0], 32'h100);
        chk("sw_strb",   {28'h0, beat_strb[0]}, 32'hF);
        chk("sw_wdata",  beat_wdata[0], 32'hDEADBEEF);
        chk("sw_we",     {31'h0, beat_we[0]}, 32'h1);
        chk("sw_mem",    tb_mem[64], 32'hDEADBEEF);
        to_idle();

        // lb @0x103, sign- then zero-extended
        tb_mem[64] = 32'h80123456;
        access(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 0, sc);
        chk("lb_sx_rdata", rdata_o, 32'hFFFFFF80);
        chk("lb_sx_strb",  {28'h0, beat_strb[0]}, 32'h8);
        chk("lb_sx_we",    {31'h0, beat_we[0]}, 32'h0);
        to_idle();
        access(32'h103, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 0, sc);
        chk("lb_zx_rdata", rdata_o, 32'h00000080);
        to_idle();

        // sh 0xABCD @0x203 splits across two words
        access(32'h203, 32'h0000ABCD, 2'b01, 1'b0, 1'b1, 1'b0, 0, sc);
        chk("sh_stall", sc, 3);
        chk("sh_beats", beat_cnt, 2);
        chk("sh_addr0", beat_addr[0], 32'h200);
        chk("sh_strb0", {28'h0, beat_strb[0]}, 32'h8);
        chk("sh_data0", beat_wdata[0], 32'hCD000000);
        chk("sh_addr1", beat_addr[1], 32'h204);
        chk("sh_strb1", {28'h0, beat_strb[1]}, 32'h1);
        chk("sh_data1", beat_wdata[1], 32'h000000AB);
        chk("sh_mem0",  tb_mem[128], 32'hCD000000);
        chk("sh_mem1",  tb_mem[129], 32'h000000AB);
        to_idle();

        // lw @0x102 reassembled from two beats
        tb_mem[64] = 32'h44332211;
        tb_mem[65] = 32'h88776655;
        access(32'h102, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 0, sc);
        chk("lw_mis_stall", sc, 3);
        chk("lw_mis_beats", beat_cnt, 2);
        chk("lw_mis_rdata", rdata_o, 32'h66554433);
        to_idle();

        // lh @0x202 sign-extended: bytes 2,3 of 0xCD000000
        access(32'h202, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 0, sc);
        chk("lh_beats", beat_cnt, 1);
        chk("lh_strb",  {28'h0, beat_strb[0]}, 32'hC);
        chk("lh_rdata", rdata_o, 32'hFFFFCD00);
        to_idle();

        // aligned lw with a slow slave: bus stays stable, stall = 1 + 5 cycles
        unstable = 0;
        access(32'h204, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 4, sc);
        chk("lw_slow_stall",  sc, 6);
        chk("lw_slow_rdata",  rdata_o, 32'h000000AB);
        chk("lw_slow_stable", unstable, 0);
        to_idle();
        chk("lw_slow_idle_req", {31'h0, mem_req_o}, 32'h0);

        // a store must not disturb the held load result
        access(32'h300, 32'h00000055, 2'b00, 1'b0, 1'b1, 1'b0, 0, sc);
        chk("sb_stall", sc, 2);
        to_idle();
        chk("sb_rdata_held", rdata_o, 32'h000000AB);

        // reset while waiting in BEAT1
        beat_cnt       = 0;
        ack_delay      = 3;
        addr_i         = 32'h102;
        mem_width_i    = 2'b10;
        mem_sign_ext_i = 1'b0;
        mem_read_i     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (beat_cnt == 1) break;
        end
        chk("rst_b1_addr", mem_addr_o, 32'h104);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_b1_req",   {31'h0, mem_req_o}, 32'h0);
        chk("rst_b1_addr0", mem_addr_o, 32'h0);
        chk("rst_b1_strb",  {28'h0, mem_wstrb_o}, 32'h0);
        chk("rst_b1_rdata", rdata_o, 32'h0);
        chk("rst_b1_stall", {31'h0, stall_o}, 32'h1);
        chk("rst_b1_beats", beat_cnt, 1);
        mem_read_i = 1'b0;
        #1;
        chk("rst_b1_stall_off", {31'h0, stall_o}, 32'h0);
        rst = 1'b0;
        to_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
